// File: rtl/arp_ctrl_pkg.sv
// Shared encodings for the ARP sequencer: FSM states, frame types
// and the broadcast destination used for requests.
package arp_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_DONE
  } arp_state_t;

  localparam logic        ARP_REQ   = 1'b0;
  localparam logic        ARP_REP   = 1'b1;
  localparam logic [47:0] BCAST_MAC = 48'hFF_FF_FF_FF_FF_FF;

  function automatic logic cache_hit(
    input logic        vld,
    input logic [31:0] entry_ip,
    input logic [31:0] ip
  );
    return vld & (entry_ip == ip);
  endfunction

endpackage

// File: rtl/arp_timeout_timer.sv
// Reply timeout counter: counts while run is high, pulses expire on
// the last cycle of the window and wraps; clr restarts it at zero.
module arp_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 12_500_000,
  parameter int TMR_W          = 24
) (
  input  logic gmii_clk,
  input  logic sys_rst,
  input  logic clr,
  input  logic run,
  output logic expire
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] cnt;

  assign expire = run & (cnt == LAST);

  always_ff @(posedge gmii_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt <= '0;
    end else if (clr | expire) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + TMR_W'(1);
    end
  end

endmodule

// File: rtl/arp_ctrl.sv
// ARP sequencer: answers requests, resolves peer IPs with retry,
// and keeps a one-entry IP->MAC cache learnt from replies.
module arp_ctrl
  import arp_ctrl_pkg::*;
#(
  parameter logic [31:0] BOARD_IP       = 32'hC0_A8_00_02,
  parameter int          TIMEOUT_CYCLES = 12_500_000,
  parameter int          MAX_RETRY      = 3,
  parameter int          TMR_W          = 24
) (
  input  logic        gmii_clk,
  input  logic        sys_rst,
  input  logic        arp_rx_done,
  input  logic        arp_rx_type,
  input  logic [47:0] src_mac,
  input  logic [31:0] src_ip,
  input  logic        gmii_tx_done,
  input  logic        ext_tx_busy,
  output logic        arp_tx_en,
  output logic        arp_tx_type,
  output logic [47:0] des_mac,
  output logic [31:0] des_ip,
  input  logic        resolve_req,
  input  logic [31:0] resolve_ip,
  output logic        resolve_done,
  output logic        resolve_fail,
  output logic [47:0] resolved_mac,
  output logic        busy
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  arp_state_t state;

  logic               rep_pend;
  logic [47:0]        peer_mac;
  logic [31:0]        peer_ip;
  logic               req_pend;
  logic               sent_req;
  logic [31:0]        tgt_ip;
  logic [RETRY_W-1:0] retry_cnt;
  logic               cache_vld;
  logic [31:0]        cache_ip;
  logic [47:0]        cache_mac;

  logic rx_req;
  logic rx_rep;
  logic got_reply;
  logic tx_fin;
  logic tmr_clr;
  logic tmr_run;
  logic tmr_expire;

  // Our own requests echoed back on a loopback are not answered.
  assign rx_req    = arp_rx_done & (arp_rx_type == ARP_REQ)
                   & (src_ip != BOARD_IP);
  assign rx_rep    = arp_rx_done & (arp_rx_type == ARP_REP);
  assign got_reply = busy & rx_rep & (src_ip == tgt_ip);
  assign tx_fin    = (state == ST_WAIT_DONE) & gmii_tx_done;

  assign tmr_clr = ~busy | (tx_fin & sent_req);
  assign tmr_run = busy & (state == ST_IDLE) & ~req_pend;

  assign resolved_mac = cache_mac;

  arp_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TMR_W         (TMR_W)
  ) u_timer (
    .gmii_clk(gmii_clk),
    .sys_rst (sys_rst),
    .clr     (tmr_clr),
    .run     (tmr_run),
    .expire  (tmr_expire)
  );

  always_ff @(posedge gmii_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= ST_IDLE;
      arp_tx_en    <= 1'b0;
      arp_tx_type  <= ARP_REQ;
      des_mac      <= '0;
      des_ip       <= '0;
      resolve_done <= 1'b0;
      resolve_fail <= 1'b0;
      busy         <= 1'b0;
      rep_pend     <= 1'b0;
      peer_mac     <= '0;
      peer_ip      <= '0;
      req_pend     <= 1'b0;
      sent_req     <= 1'b0;
      tgt_ip       <= '0;
      retry_cnt    <= '0;
      cache_vld    <= 1'b0;
      cache_ip     <= '0;
      cache_mac    <= '0;
    end else begin
      arp_tx_en    <= 1'b0;
      resolve_done <= 1'b0;
      resolve_fail <= 1'b0;

      if (rx_rep) begin
        cache_vld <= 1'b1;
        cache_ip  <= src_ip;
        cache_mac <= src_mac;
      end

      unique case (state)
        ST_IDLE: begin
          if (~ext_tx_busy & (rep_pend | req_pend)) begin
            state     <= ST_SEND;
            arp_tx_en <= 1'b1;
            if (rep_pend) begin
              arp_tx_type <= ARP_REP;
              des_mac     <= peer_mac;
              des_ip      <= peer_ip;
              rep_pend    <= 1'b0;
              sent_req    <= 1'b0;
            end else begin
              arp_tx_type <= ARP_REQ;
              des_mac     <= BCAST_MAC;
              des_ip      <= tgt_ip;
              req_pend    <= 1'b0;
              sent_req    <= 1'b1;
              retry_cnt   <= retry_cnt + RETRY_W'(1);
            end
          end
        end
        ST_SEND: state <= ST_WAIT_DONE;
        ST_WAIT_DONE: begin
          if (gmii_tx_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // A request arriving during launch re-arms the reply.
      if (rx_req) begin
        rep_pend <= 1'b1;
        peer_mac <= src_mac;
        peer_ip  <= src_ip;
      end

      if (got_reply) begin
        resolve_done <= 1'b1;
        busy         <= 1'b0;
        req_pend     <= 1'b0;
      end else if (busy & tmr_expire) begin
        if (retry_cnt < RETRY_MAX) begin
          req_pend <= 1'b1;
        end else begin
          resolve_fail <= 1'b1;
          busy         <= 1'b0;
        end
      end else if (resolve_req & ~busy) begin
        if (cache_hit(cache_vld, cache_ip, resolve_ip)) begin
          resolve_done <= 1'b1;
        end else begin
          busy      <= 1'b1;
          req_pend  <= 1'b1;
          tgt_ip    <= resolve_ip;
          retry_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_arp_ctrl.sv
// Directed bench for arp_ctrl with a loopback model of the arp
// engine that answers every launch with gmii_tx_done.
module tb_arp_ctrl;

  localparam int TO = 100;
  localparam int FL = 20;
  localparam logic [47:0] BC = 48'hFF_FF_FF_FF_FF_FF;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        arp_rx_done = 1'b0;
  logic        arp_rx_type = 1'b0;
  logic [47:0] src_mac = '0;
  logic [31:0] src_ip = '0;
  logic        gmii_tx_done;
  logic        ext_tx_busy = 1'b0;
  logic        arp_tx_en;
  logic        arp_tx_type;
  logic [47:0] des_mac;
  logic [31:0] des_ip;
  logic        resolve_req = 1'b0;
  logic [31:0] resolve_ip = '0;
  logic        resolve_done;
  logic        resolve_fail;
  logic [47:0] resolved_mac;
  logic        busy;

  arp_ctrl #(
    .TIMEOUT_CYCLES(TO),
    .MAX_RETRY     (2),
    .TMR_W         (24)
  ) dut (
    .gmii_clk    (clk),
    .sys_rst     (sys_rst),
    .arp_rx_done (arp_rx_done),
    .arp_rx_type (arp_rx_type),
    .src_mac     (src_mac),
    .src_ip      (src_ip),
    .gmii_tx_done(gmii_tx_done),
    .ext_tx_busy (ext_tx_busy),
    .arp_tx_en   (arp_tx_en),
    .arp_tx_type (arp_tx_type),
    .des_mac     (des_mac),
    .des_ip      (des_ip),
    .resolve_req (resolve_req),
    .resolve_ip  (resolve_ip),
    .resolve_done(resolve_done),
    .resolve_fail(resolve_fail),
    .resolved_mac(resolved_mac),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  int          tx_cnt = 0;
  int          txd_cnt = 0;
  int          txd_cyc = 0;
  logic        tx_type [32];
  logic [47:0] tx_mac  [32];
  logic [31:0] tx_ip   [32];
  int          tx_cyc  [32];
  int          done_cnt = 0;
  int          fail_cnt = 0;
  int          fail_cyc = 0;

  initial begin
    gmii_tx_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (arp_tx_en && !sys_rst) begin
        if (tx_cnt < 32) begin
          tx_type[tx_cnt] = arp_tx_type;
          tx_mac[tx_cnt]  = des_mac;
          tx_ip[tx_cnt]   = des_ip;
          tx_cyc[tx_cnt]  = cyc;
        end
        tx_cnt++;
        repeat (FL) @(posedge clk);
        #1 gmii_tx_done = 1'b1;
        @(posedge clk);
        #1 gmii_tx_done = 1'b0;
        txd_cyc = cyc;
        txd_cnt++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (resolve_done) done_cnt++;
    if (resolve_fail) begin
      fail_cnt++;
      fail_cyc = cyc;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic int cnt_of(input int w);
    case (w)
      0:       return tx_cnt;
      1:       return txd_cnt;
      2:       return done_cnt;
      default: return fail_cnt;
    endcase
  endfunction

  task automatic wait_cnt(input int w, input int n, input int budget,
                          input string nm);
    int k = 0;
    while (cnt_of(w) < n && k < budget) begin
      tick();
      k++;
    end
    chk(nm, 64'(cnt_of(w) >= n), 64'd1);
  endtask

  task automatic pulse_rx(input logic t, input logic [31:0] ip,
                          input logic [47:0] mac);
    tick();
    arp_rx_done = 1'b1;
    arp_rx_type = t;
    src_ip      = ip;
    src_mac     = mac;
    tick();
    arp_rx_done = 1'b0;
  endtask

  task automatic pulse_res(input logic [31:0] ip);
    tick();
    resolve_req = 1'b1;
    resolve_ip  = ip;
    tick();
    resolve_req = 1'b0;
  endtask

  typedef struct {
    logic        rtype;
    logic [31:0] ip;
    logic [47:0] mac;
    logic        en;
    logic        ttype;
    logic [47:0] dmac;
    logic [31:0] dip;
    logic [47:0] rmac;
  } vec_t;

  vec_t vt [4];

  initial begin
    int base;
    int bd;
    int seen;
    vt[0] = '{1'b0, 32'hC0A80003, 48'h001122334455,
              1'b1, 1'b1, 48'h001122334455, 32'hC0A80003, 48'h0};
    vt[1] = '{1'b0, 32'hC0A80004, 48'h0200DEADBEEF,
              1'b1, 1'b1, 48'h0200DEADBEEF, 32'hC0A80004, 48'h0};
    vt[2] = '{1'b1, 32'hC0A8000B, 48'h66778899AABB,
              1'b0, 1'b0, 48'h0, 32'h0, 48'h66778899AABB};
    vt[3] = '{1'b0, 32'hC0A80006, 48'h00A0C9112233,
              1'b1, 1'b1, 48'h00A0C9112233, 32'hC0A80006,
              48'h66778899AABB};

    #23;
    chk("rst_tx_en", 64'(arp_tx_en), 64'd0);
    chk("rst_des_mac", 64'(des_mac), 64'd0);
    chk("rst_des_ip", 64'(des_ip), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rmac", 64'(resolved_mac), 64'd0);
    tick();
    sys_rst = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 4; i++) begin
      pulse_rx(vt[i].rtype, vt[i].ip, vt[i].mac);
      chk($sformatf("v%0d_en_n1", i), 64'(arp_tx_en), 64'd0);
      tick();
      chk($sformatf("v%0d_en_n2", i), 64'(arp_tx_en), 64'(vt[i].en));
      chk($sformatf("v%0d_rmac", i), 64'(resolved_mac), 64'(vt[i].rmac));
      if (vt[i].en) begin
        chk($sformatf("v%0d_type", i), 64'(arp_tx_type), 64'(vt[i].ttype));
        chk($sformatf("v%0d_dmac", i), 64'(des_mac), 64'(vt[i].dmac));
        chk($sformatf("v%0d_dip", i), 64'(des_ip), 64'(vt[i].dip));
        tick();
        chk($sformatf("v%0d_en_pulse", i), 64'(arp_tx_en), 64'd0);
      end
      repeat (FL + 5) tick();
    end

    // Unanswered resolve: two broadcasts, then fail.
    base = tx_cnt;
    pulse_res(32'hC0A80003);
    chk("t2_busy", 64'(busy), 64'd1);
    wait_cnt(0, base + 1, 10, "t2_tx1_wait");
    chk("t2_tx1_type", 64'(tx_type[base]), 64'(1'b0));
    chk("t2_tx1_mac", 64'(tx_mac[base]), 64'(BC));
    chk("t2_tx1_ip", 64'(tx_ip[base]), 64'(32'hC0A80003));
    wait_cnt(0, base + 2, 300, "t2_tx2_wait");
    chk("t2_gap", 64'(tx_cyc[base+1] - tx_cyc[base]), 64'(FL + 1 + TO + 1));
    chk("t2_tx2_mac", 64'(tx_mac[base+1]), 64'(BC));
    bd = fail_cnt;
    wait_cnt(3, bd + 1, 300, "t2_fail_wait");
    chk("t2_fail_lat", 64'(fail_cyc - txd_cyc), 64'(TO));
    chk("t2_busy_fall", 64'(busy), 64'd0);
    repeat (TO + 30) tick();
    chk("t2_no_3rd", 64'(tx_cnt), 64'(base + 2));

    // Reply 40 cycles after first tx_done completes the resolve.
    base = tx_cnt;
    bd = txd_cnt;
    pulse_res(32'hC0A80005);
    wait_cnt(1, bd + 1, 60, "t3_txd_wait");
    repeat (40) tick();
    pulse_rx(1'b1, 32'hC0A80005, 48'hAABBCCDDEEFF);
    chk("t3_done", 64'(resolve_done), 64'd1);
    chk("t3_rmac", 64'(resolved_mac), 64'hAABBCCDDEEFF);
    chk("t3_busy", 64'(busy), 64'd0);
    tick();
    chk("t3_done_pulse", 64'(resolve_done), 64'd0);
    pulse_res(32'hC0A80005);
    chk("t3_hit_done", 64'(resolve_done), 64'd1);
    chk("t3_hit_busy", 64'(busy), 64'd0);
    repeat (TO + 20) tick();
    chk("t3_tx_cnt", 64'(tx_cnt), 64'(base + 1));

    // Request rx and resolve_req together: reply first, then request.
    base = tx_cnt;
    bd = txd_cnt;
    tick();
    arp_rx_done = 1'b1;
    arp_rx_type = 1'b0;
    src_ip      = 32'hC0A80009;
    src_mac     = 48'h0A0B0C0D0E0F;
    resolve_req = 1'b1;
    resolve_ip  = 32'hC0A80007;
    tick();
    arp_rx_done = 1'b0;
    resolve_req = 1'b0;
    wait_cnt(0, base + 2, 100, "t4_tx_wait");
    chk("t4_first_type", 64'(tx_type[base]), 64'(1'b1));
    chk("t4_first_ip", 64'(tx_ip[base]), 64'(32'hC0A80009));
    chk("t4_first_mac", 64'(tx_mac[base]), 64'h0A0B0C0D0E0F);
    chk("t4_second_type", 64'(tx_type[base+1]), 64'(1'b0));
    chk("t4_second_ip", 64'(tx_ip[base+1]), 64'(32'hC0A80007));
    chk("t4_second_mac", 64'(tx_mac[base+1]), 64'(BC));
    wait_cnt(1, bd + 2, 60, "t4_txd_wait");
    pulse_rx(1'b1, 32'hC0A80007, 48'h5A5A5A5A5A5A);
    chk("t4_done", 64'(resolve_done), 64'd1);
    chk("t4_busy", 64'(busy), 64'd0);

    // ext_tx_busy holds off the reply; then reset during WAIT_DONE.
    repeat (5) tick();
    ext_tx_busy = 1'b1;
    pulse_rx(1'b0, 32'hC0A8000A, 48'h0A1B2C3D4E5F);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (arp_tx_en) seen++;
    end
    chk("t5_held", 64'(seen), 64'd0);
    ext_tx_busy = 1'b0;
    tick();
    chk("t5_release_en", 64'(arp_tx_en), 64'd1);
    chk("t5_release_ip", 64'(des_ip), 64'(32'hC0A8000A));
    repeat (5) tick();
    sys_rst = 1'b1;
    #2;
    chk("t5_rst_mac", 64'(des_mac), 64'd0);
    chk("t5_rst_ip", 64'(des_ip), 64'd0);
    chk("t5_rst_type", 64'(arp_tx_type), 64'd0);
    chk("t5_rst_rmac", 64'(resolved_mac), 64'd0);
    repeat (3) tick();
    sys_rst = 1'b0;
    base = tx_cnt;
    repeat (60) tick();
    chk("t5_no_launch", 64'(tx_cnt), 64'(base));
    bd = done_cnt;
    pulse_res(32'hC0A80007);
    chk("t5_cache_clr_busy", 64'(busy), 64'd1);
    chk("t5_cache_clr_done", 64'(done_cnt), 64'(bd));
    wait_cnt(0, base + 1, 10, "t5_req_wait");
    chk("t5_req_ip", 64'(tx_ip[base]), 64'(32'hC0A80007));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
